udp_parser_mc: RTL and testbench

Multi-channel successor to the single-port UDP parser. Takes a byte stream of UDP datagrams framed by in_last and parses the 8-byte header. The destination port is matched against a table of NUM_PORTS targets. Matched payloads are forwarded on a registered valid/ready stream tagged with the channel index; other packets are discarded. Adds length validation, error reporting and saturating accept/drop counters, and sits between the IP de-encapsulator and per-port payload consumers.

---
 rtl/udp_parser_pkg.sv | 20 ++
 rtl/udp_port_match.sv | 24 ++
 rtl/udp_parser_mc.sv | 165 ++++++++++++++++
 tb/tb_udp_parser_mc.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_parser_pkg.sv
// Shared types and constants for the multi-channel UDP parser.
package udp_parser_pkg;

   typedef enum logic [1:0] {
      HDR     = 2'd0,
      PAYLOAD = 2'd1,
      DROP    = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_SHORT_LEN = 2'd1,
      ERR_TRUNC     = 2'd2,
      ERR_TRAIL     = 2'd3
   } err_code_t;

   localparam int unsigned UDP_HDR_BYTES = 8;
   localparam int unsigned PORT_W        = 16;

endpackage

// File: rtl/udp_port_match.sv
// Combinational priority matcher: lowest enabled table entry equal to dst wins.
module udp_port_match #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned CHAN_W    = 2
) (
   input  logic [NUM_PORTS*16-1:0] port_table,
   input  logic [NUM_PORTS-1:0]    port_enable,
   input  logic [15:0]             dst,
   output logic                    hit,
   output logic [CHAN_W-1:0]       idx
);

   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (!hit && port_enable[i] && (port_table[16*i +: 16] == dst)) begin
            hit = 1'b1;
            idx = CHAN_W'(i);
         end
      end
   end

endmodule

// File: rtl/udp_parser_mc.sv
// UDP header parser with a multi-entry destination-port table; forwards matched
// payload tagged with the table index and reports length errors.
module udp_parser_mc
   import udp_parser_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned CHAN_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_PORTS*16-1:0] port_table,
   input  logic [NUM_PORTS-1:0]    port_enable,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   input  logic                    in_last,
   output logic                    in_ready,
   output logic [7:0]              out_data,
   output logic                    out_valid,
   output logic                    out_last,
   output logic [CHAN_W-1:0]       out_chan,
   input  logic                    out_ready,
   output logic                    hdr_valid,
   output logic                    hdr_match,
   output logic [15:0]             src_port,
   output logic [15:0]             dst_port,
   output logic [15:0]             length,
   output logic                    err_valid,
   output logic [1:0]              err_code,
   output logic [CNT_W-1:0]        pkt_accept_cnt,
   output logic [CNT_W-1:0]        pkt_drop_cnt
);

   localparam logic [15:0]      HDR_LEN = 16'(UDP_HDR_BYTES);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t             state;
   logic [2:0]         byte_cnt;
   logic [47:0]        hdr_sr;      // header bytes 0..5; checksum is never stored
   logic [15:0]        remaining;
   logic               accept;
   logic [15:0]        f_src;
   logic [15:0]        f_dst;
   logic [15:0]        f_len;
   logic               hit;
   logic [CHAN_W-1:0]  hit_idx;

   assign f_src    = hdr_sr[47:32];
   assign f_dst    = hdr_sr[31:16];
   assign f_len    = hdr_sr[15:0];
   assign in_ready = (state != PAYLOAD) || !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   udp_port_match #(
      .NUM_PORTS (NUM_PORTS),
      .CHAN_W    (CHAN_W)
   ) u_match (
      .port_table  (port_table),
      .port_enable (port_enable),
      .dst         (f_dst),
      .hit         (hit),
      .idx         (hit_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= HDR;
         byte_cnt       <= '0;
         hdr_sr         <= '0;
         remaining      <= '0;
         out_data       <= '0;
         out_valid      <= 1'b0;
         out_last       <= 1'b0;
         out_chan       <= '0;
         hdr_valid      <= 1'b0;
         hdr_match      <= 1'b0;
         src_port       <= '0;
         dst_port       <= '0;
         length         <= '0;
         err_valid      <= 1'b0;
         err_code       <= ERR_NONE;
         pkt_accept_cnt <= '0;
         pkt_drop_cnt   <= '0;
      end else begin
         hdr_valid <= 1'b0;
         err_valid <= 1'b0;
         err_code  <= ERR_NONE;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            case (state)
               HDR: begin
                  if (byte_cnt != 3'd7) begin
                     if (byte_cnt < 3'd6) begin
                        hdr_sr <= {hdr_sr[39:0], in_data};
                     end
                     if (in_last) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_TRUNC;
                        byte_cnt  <= '0;
                        if (pkt_drop_cnt != CNT_MAX) pkt_drop_cnt <= pkt_drop_cnt + CNT_W'(1);
                     end else begin
                        byte_cnt <= byte_cnt + 3'd1;
                     end
                  end else begin
                     // Byte 7: publish the header and decide the packet's fate.
                     byte_cnt  <= '0;
                     src_port  <= f_src;
                     dst_port  <= f_dst;
                     length    <= f_len;
                     hdr_valid <= 1'b1;
                     hdr_match <= 1'b0;
                     remaining <= f_len - HDR_LEN;
                     if (f_len < HDR_LEN) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_SHORT_LEN;
                        if (pkt_drop_cnt != CNT_MAX) pkt_drop_cnt <= pkt_drop_cnt + CNT_W'(1);
                     end else if (!hit) begin
                        if (pkt_drop_cnt != CNT_MAX) pkt_drop_cnt <= pkt_drop_cnt + CNT_W'(1);
                     end else begin
                        hdr_match <= 1'b1;
                        out_chan  <= hit_idx;
                        if (pkt_accept_cnt != CNT_MAX) pkt_accept_cnt <= pkt_accept_cnt + CNT_W'(1);
                     end
                     if (in_last) begin
                        state <= HDR;
                     end else if (hit && (f_len > HDR_LEN)) begin
                        state <= PAYLOAD;
                     end else begin
                        state <= DROP;
                     end
                  end
               end
               PAYLOAD: begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  out_last  <= (remaining == 16'd1) || in_last;
                  remaining <= remaining - 16'd1;
                  if (remaining == 16'd1) begin
                     if (in_last) begin
                        state <= HDR;
                     end else begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_TRAIL;
                        state     <= DROP;
                     end
                  end else if (in_last) begin
                     err_valid <= 1'b1;
                     err_code  <= ERR_TRUNC;
                     state     <= HDR;
                  end
               end
               DROP: begin
                  if (in_last) begin
                     state <= HDR;
                  end
               end
               default: state <= HDR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_udp_parser_mc.sv
// Directed scoreboard bench for udp_parser_mc.
module tb_udp_parser_mc;

   localparam int NP   = 4;
   localparam int CW   = 2;
   localparam int CNTW = 16;

   logic             clk;
   logic             rst;
   logic [NP*16-1:0] port_table;
   logic [NP-1:0]    port_enable;
   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_last;
   logic [CW-1:0]    out_chan;
   logic             out_ready;
   logic             hdr_valid;
   logic             hdr_match;
   logic [15:0]      src_port;
   logic [15:0]      dst_port;
   logic [15:0]      length;
   logic             err_valid;
   logic [1:0]       err_code;
   logic [CNTW-1:0]  pkt_accept_cnt;
   logic [CNTW-1:0]  pkt_drop_cnt;

   udp_parser_mc #(.NUM_PORTS(NP), .CHAN_W(CW), .CNT_W(CNTW)) dut (
      .clk(clk), .rst(rst), .port_table(port_table), .port_enable(port_enable),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_chan(out_chan),
      .out_ready(out_ready), .hdr_valid(hdr_valid), .hdr_match(hdr_match),
      .src_port(src_port), .dst_port(dst_port), .length(length),
      .err_valid(err_valid), .err_code(err_code),
      .pkt_accept_cnt(pkt_accept_cnt), .pkt_drop_cnt(pkt_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]    d;
      logic          l;
      logic [CW-1:0] c;
   } ob_t;

   typedef struct packed {
      logic [15:0]   src;
      logic [15:0]   dst;
      logic [15:0]   len;
      logic          m;
      logic          chk_m;
      logic [CW-1:0] c;
   } he_t;

   ob_t        out_q[$];
   he_t        hdr_q[$];
   logic [1:0] err_q[$];
   logic [7:0] pkt[$];
   string      msg = "TEST TEST";
   int         checks = 0;
   int         errors = 0;
   bit         rdy_mode = 1'b0;
   ob_t        mon_o;
   he_t        mon_h;
   logic [1:0] mon_e;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Output-side monitors pop the scoreboard on every observed event.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            check("out_expected", 32'(out_q.size() != 0), 32'd1);
            if (out_q.size() != 0) begin
               mon_o = out_q.pop_front();
               check("out_data", 32'(out_data), 32'(mon_o.d));
               check("out_last", 32'(out_last), 32'(mon_o.l));
               check("out_chan", 32'(out_chan), 32'(mon_o.c));
            end
         end
         if (hdr_valid) begin
            check("hdr_expected", 32'(hdr_q.size() != 0), 32'd1);
            if (hdr_q.size() != 0) begin
               mon_h = hdr_q.pop_front();
               check("src_port", 32'(src_port), 32'(mon_h.src));
               check("dst_port", 32'(dst_port), 32'(mon_h.dst));
               check("length", 32'(length), 32'(mon_h.len));
               if (mon_h.chk_m) check("hdr_match", 32'(hdr_match), 32'(mon_h.m));
               if (mon_h.m && mon_h.chk_m) check("hdr_chan", 32'(out_chan), 32'(mon_h.c));
            end
         end
         if (err_valid) begin
            check("err_expected", 32'(err_q.size() != 0), 32'd1);
            if (err_q.size() != 0) begin
               mon_e = err_q.pop_front();
               check("err_code", 32'(err_code), 32'(mon_e));
            end
         end
      end
   end

   always begin
      @(posedge clk);
      #1;
      out_ready = rdy_mode ? ~out_ready : 1'b1;
   end

   task automatic build(input logic [15:0] src, input logic [15:0] dst,
                        input logic [15:0] len, input int n);
      pkt.delete();
      pkt.push_back(src[15:8]); pkt.push_back(src[7:0]);
      pkt.push_back(dst[15:8]); pkt.push_back(dst[7:0]);
      pkt.push_back(len[15:8]); pkt.push_back(len[7:0]);
      pkt.push_back(8'h00);     pkt.push_back(8'h00);
      for (int k = 0; k < n - 8; k++) begin
         if (k < 9) pkt.push_back(msg[k]);
         else       pkt.push_back(8'(8'hA0 + k));
      end
   endtask

   task automatic exp_hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                          input logic m, input logic chk, input logic [CW-1:0] c);
      he_t h;
      h.src = src; h.dst = dst; h.len = len; h.m = m; h.chk_m = chk; h.c = c;
      hdr_q.push_back(h);
   endtask

   // Expect the first cnt payload bytes; the final one flagged last when fin is set.
   task automatic exp_pay(input int cnt, input logic [CW-1:0] c, input bit fin);
      ob_t o;
      for (int k = 0; k < cnt; k++) begin
         o.d = pkt[8 + k];
         o.l = fin && (k == cnt - 1);
         o.c = c;
         out_q.push_back(o);
      end
   endtask

   task automatic send(input int first, input int stop, input bit with_last);
      for (int i = first; i < stop; i++) begin
         bit acc;
         int t;
         in_data  = pkt[i];
         in_valid = 1'b1;
         in_last  = with_last && (i == stop - 1);
         acc = 1'b0;
         t   = 0;
         while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
         end
         if (!acc) check("send_timeout", 32'd0, 32'd1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic settle(input string tag);
      repeat (30) @(posedge clk);
      #1;
      check({tag, "_out_q"}, 32'(out_q.size()), 32'd0);
      check({tag, "_hdr_q"}, 32'(hdr_q.size()), 32'd0);
      check({tag, "_err_q"}, 32'(err_q.size()), 32'd0);
   endtask

   task automatic check_cnts(input string tag, input int acc, input int drp);
      check({tag, "_accept"}, 32'(pkt_accept_cnt), 32'(acc));
      check({tag, "_drop"}, 32'(pkt_drop_cnt), 32'(drp));
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_data"}, 32'(out_data), 32'd0);
      check({tag, "_out_chan"}, 32'(out_chan), 32'd0);
      check({tag, "_hdr_valid"}, 32'(hdr_valid), 32'd0);
      check({tag, "_hdr_match"}, 32'(hdr_match), 32'd0);
      check({tag, "_src"}, 32'(src_port), 32'd0);
      check({tag, "_len"}, 32'(length), 32'd0);
      check({tag, "_err_valid"}, 32'(err_valid), 32'd0);
      check_cnts(tag, 0, 0);
   endtask

   initial begin
      rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      port_table  = {16'd9999, 16'd53, 16'd80, 16'd1234};
      port_enable = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic match on entry 0
      build(16'd49152, 16'd1234, 16'd17, 17);
      exp_hdr(16'd49152, 16'd1234, 16'd17, 1'b1, 1'b1, 2'd0);
      exp_pay(9, 2'd0, 1'b1);
      send(0, 17, 1'b1);
      settle("t1");
      check_cnts("t1", 1, 0);

      // Entry 2, then an unmatched port, then a normal packet
      build(16'd49152, 16'd53, 16'd17, 17);
      exp_hdr(16'd49152, 16'd53, 16'd17, 1'b1, 1'b1, 2'd2);
      exp_pay(9, 2'd2, 1'b1);
      send(0, 17, 1'b1);
      build(16'd49152, 16'd7, 16'd17, 17);
      exp_hdr(16'd49152, 16'd7, 16'd17, 1'b0, 1'b1, 2'd0);
      send(0, 17, 1'b1);
      build(16'd4000, 16'd80, 16'd12, 12);
      exp_hdr(16'd4000, 16'd80, 16'd12, 1'b1, 1'b1, 2'd1);
      exp_pay(4, 2'd1, 1'b1);
      send(0, 12, 1'b1);
      settle("t2");
      check_cnts("t2", 3, 1);

      // Priority with a disabled duplicate; table change mid-payload
      port_table  = {16'd80, 16'd53, 16'd80, 16'd1234};
      port_enable = 4'b1101;
      build(16'd49152, 16'd80, 16'd17, 17);
      exp_hdr(16'd49152, 16'd80, 16'd17, 1'b1, 1'b1, 2'd3);
      exp_pay(9, 2'd3, 1'b1);
      send(0, 12, 1'b0);
      port_table  = {16'd80, 16'd80, 16'd80, 16'd80};
      port_enable = 4'hF;
      send(12, 17, 1'b1);
      settle("t3");
      check("t3_chan_hold", 32'(out_chan), 32'd3);
      check_cnts("t3", 4, 1);

      // Truncated payload, short length, truncated header, zero-length payload
      port_table  = {16'd9999, 16'd53, 16'd80, 16'd1234};
      port_enable = 4'hF;
      build(16'd49152, 16'd1234, 16'd17, 17);
      exp_hdr(16'd49152, 16'd1234, 16'd17, 1'b1, 1'b1, 2'd0);
      exp_pay(4, 2'd0, 1'b1);
      err_q.push_back(2'd2);
      send(0, 12, 1'b1);
      build(16'd49152, 16'd1234, 16'd5, 12);
      exp_hdr(16'd49152, 16'd1234, 16'd5, 1'b0, 1'b0, 2'd0);
      err_q.push_back(2'd1);
      send(0, 12, 1'b1);
      build(16'd1, 16'd1234, 16'd17, 17);
      err_q.push_back(2'd2);
      send(0, 5, 1'b1);
      build(16'd49152, 16'd53, 16'd8, 8);
      exp_hdr(16'd49152, 16'd53, 16'd8, 1'b1, 1'b1, 2'd2);
      send(0, 8, 1'b1);
      settle("t4");
      check_cnts("t4", 6, 3);

      // Trailing bytes beyond the length field, then a clean packet
      build(16'd49152, 16'd1234, 16'd10, 13);
      exp_hdr(16'd49152, 16'd1234, 16'd10, 1'b1, 1'b1, 2'd0);
      exp_pay(2, 2'd0, 1'b1);
      err_q.push_back(2'd3);
      send(0, 13, 1'b1);
      build(16'd49152, 16'd1234, 16'd17, 17);
      exp_hdr(16'd49152, 16'd1234, 16'd17, 1'b1, 1'b1, 2'd0);
      exp_pay(9, 2'd0, 1'b1);
      send(0, 17, 1'b1);
      settle("t5");
      check_cnts("t5", 8, 3);

      // Back-pressure with out_ready alternating
      rdy_mode = 1'b1;
      build(16'd2222, 16'd9999, 16'd17, 17);
      exp_hdr(16'd2222, 16'd9999, 16'd17, 1'b1, 1'b1, 2'd3);
      exp_pay(9, 2'd3, 1'b1);
      send(0, 17, 1'b1);
      build(16'd3333, 16'd80, 16'd14, 14);
      exp_hdr(16'd3333, 16'd80, 16'd14, 1'b1, 1'b1, 2'd1);
      exp_pay(6, 2'd1, 1'b1);
      send(0, 14, 1'b1);
      settle("t6");
      rdy_mode = 1'b0;
      check_cnts("t6", 10, 3);

      // Reset in the middle of a payload
      build(16'd49152, 16'd1234, 16'd17, 17);
      exp_hdr(16'd49152, 16'd1234, 16'd17, 1'b1, 1'b1, 2'd0);
      exp_pay(3, 2'd0, 1'b0);
      send(0, 11, 1'b0);
      settle("t7_pre");
      rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("t7_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      build(16'd5555, 16'd53, 16'd11, 11);
      exp_hdr(16'd5555, 16'd53, 16'd11, 1'b1, 1'b1, 2'd2);
      exp_pay(3, 2'd2, 1'b1);
      send(0, 11, 1'b1);
      settle("t7");
      check_cnts("t7", 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
